sync_fpd: RTL and testbench

//  Sequential IEEE-754 single-precision divider, the inverse operation of the registered FP multiplier.

---
 rtl/fpd_pkg.sv | 42 ++++
 rtl/fpd_mant_div.sv | 58 +++++
 rtl/sync_fpd.sv | 116 +++++++++++
 tb/tb_sync_fpd.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/fpd_pkg.sv
// rtl/fpd_pkg.sv - shared types, constants and special-operand decode for the sync_fpd divider
package fpd_pkg;

    typedef enum logic [1:0] {IDLE, CALC, NORM, DONE} fpd_state_t;

    localparam logic [31:0] QNAN    = 32'h7FC00000;
    localparam logic [31:0] POS_INF = 32'h7F800000;
    localparam int          EXP_MAX = 255;
    localparam int          ITER    = 25;

    typedef struct packed {
        logic        hit;
        logic [31:0] val;
    } fpd_special_t;

    // Denormals flush to zero; the isZero sideband overrides the encoded value.
    function automatic fpd_special_t fpd_classify(input logic [31:0] a, input logic za,
                                                  input logic [31:0] b, input logic zb);
        fpd_special_t r;
        logic sign, zero_a, zero_b, inf_a, inf_b, nan_a, nan_b;
        sign   = a[31] ^ b[31];
        zero_a = za || (a[30:23] == 8'd0);
        zero_b = zb || (b[30:23] == 8'd0);
        inf_a  = !za && (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
        inf_b  = !zb && (b[30:23] == 8'hFF) && (b[22:0] == 23'd0);
        nan_a  = !za && (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
        nan_b  = !zb && (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
        r.hit  = 1'b1;
        if (nan_a || nan_b || (zero_a && zero_b) || (inf_a && inf_b))
            r.val = QNAN;
        else if (zero_b || inf_a)
            r.val = POS_INF | {sign, 31'd0};
        else if (zero_a || inf_b)
            r.val = {sign, 31'd0};
        else begin
            r.hit = 1'b0;
            r.val = 32'd0;
        end
        return r;
    endfunction

endpackage

// File: rtl/fpd_mant_div.sv
// rtl/fpd_mant_div.sv - radix-2 restoring mantissa divider, q = floor(ma*2^(MANT_W)/mb), one bit per cycle
module fpd_mant_div
    import fpd_pkg::*;
#(
    parameter int MANT_W = 24
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [MANT_W-1:0] ma,
    input  logic [MANT_W-1:0] mb,
    output logic              busy,
    output logic              valid,
    output logic [MANT_W:0]   q
);

    logic [MANT_W-1:0] div_r;
    logic [MANT_W:0]   rem;
    logic [MANT_W:0]   shifted;
    logic              ge;
    logic [4:0]        cnt;

    always_comb begin
        shifted = {rem[MANT_W-1:0], 1'b0};
        ge      = shifted >= {1'b0, div_r};
    end

    // The load edge resolves the integer quotient bit, so the remaining 24 bits
    // finish 24 cycles later and valid pulses right after the 25th bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_r <= '0;
            rem   <= '0;
            q     <= '0;
            cnt   <= '0;
            busy  <= 1'b0;
            valid <= 1'b0;
        end else begin
            valid <= 1'b0;
            if (load) begin
                div_r <= mb;
                rem   <= (ma >= mb) ? {1'b0, ma - mb} : {1'b0, ma};
                q     <= {{MANT_W{1'b0}}, (ma >= mb)};
                cnt   <= 5'd1;
                busy  <= 1'b1;
            end else if (busy) begin
                rem <= ge ? shifted - {1'b0, div_r} : shifted;
                q   <= {q[MANT_W-1:0], ge};
                cnt <= cnt + 5'd1;
                if (cnt == 5'(ITER - 1)) begin
                    busy  <= 1'b0;
                    valid <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/sync_fpd.sv
// rtl/sync_fpd.sv - sequential IEEE-754 single divider; FPD_DIVZERO_FLAG_EN adds the divByZero output
module sync_fpd
    import fpd_pkg::*;
#(
    parameter int MANT_W = 24,
    parameter int EXP_W  = 8,
    parameter int BIAS   = 127
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] A,
    input  logic        isZeroA,
    input  logic [31:0] B,
    input  logic        isZeroB,
    output logic        busy,
    output logic        done,
    output logic [31:0] quotient,
    output logic        isZeroOut
`ifdef FPD_DIVZERO_FLAG_EN
    ,
    output logic        divByZero
`endif
);

    fpd_state_t        state;
    fpd_special_t      spec_in, spec_r;
    logic              sign_r;
    logic [EXP_W-1:0]  ea_r, eb_r;
    logic [31:0]       res_r, norm_val;
    logic              div_load, div_busy, div_valid;
    logic [MANT_W:0]   div_q;
    logic signed [9:0] e_raw, e_adj;
    logic [MANT_W-2:0] frac;
`ifdef FPD_DIVZERO_FLAG_EN
    logic              dbz_r;
`endif

    assign spec_in  = fpd_classify(A, isZeroA, B, isZeroB);
    assign div_load = (state == IDLE) && start && !spec_in.hit;

    fpd_mant_div #(.MANT_W(MANT_W)) u_mant_div (
        .clk   (clk),
        .rst   (rst),
        .load  (div_load),
        .ma    ({1'b1, A[MANT_W-2:0]}),
        .mb    ({1'b1, B[MANT_W-2:0]}),
        .busy  (div_busy),
        .valid (div_valid),
        .q     (div_q)
    );

    always_comb begin
        e_raw = 10'(ea_r) - 10'(eb_r) + 10'(BIAS);
        e_adj = div_q[MANT_W] ? e_raw : e_raw - 10'sd1;
        frac  = div_q[MANT_W] ? div_q[MANT_W-1:1] : div_q[MANT_W-2:0];
        if (e_adj >= $signed(10'(EXP_MAX)))
            norm_val = POS_INF | {sign_r, 31'd0};
        else if (e_adj < 10'sd1)
            norm_val = {sign_r, 31'd0};
        else
            norm_val = {sign_r, e_adj[EXP_W-1:0], frac};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            quotient  <= '0;
            isZeroOut <= 1'b0;
            spec_r    <= '0;
            sign_r    <= 1'b0;
            ea_r      <= '0;
            eb_r      <= '0;
            res_r     <= '0;
`ifdef FPD_DIVZERO_FLAG_EN
            dbz_r     <= 1'b0;
            divByZero <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    spec_r <= spec_in;
                    sign_r <= A[31] ^ B[31];
                    ea_r   <= A[30:23];
                    eb_r   <= B[30:23];
                    busy   <= 1'b1;
`ifdef FPD_DIVZERO_FLAG_EN
                    dbz_r  <= (isZeroB || B[30:23] == 8'd0) && !isZeroA &&
                              (A[30:23] != 8'd0) && (A[30:23] != 8'hFF);
`endif
                    state  <= spec_in.hit ? NORM : CALC;
                end
                CALC: if (div_valid && !div_busy) state <= NORM;
                NORM: begin
                    res_r <= spec_r.hit ? spec_r.val : norm_val;
                    state <= DONE;
                end
                DONE: begin
                    quotient  <= res_r;
                    isZeroOut <= (res_r[30:0] == 31'd0);
                    done      <= 1'b1;
                    busy      <= 1'b0;
`ifdef FPD_DIVZERO_FLAG_EN
                    divByZero <= dbz_r;
`endif
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sync_fpd.sv
// tb/tb_sync_fpd.sv - scoreboard bench for sync_fpd: directed operands, monitor checks each done pulse
module tb_sync_fpd;

    logic        clk = 1'b0;
    logic        rst, start, isZeroA, isZeroB;
    logic [31:0] A, B;
    logic        busy, done, isZeroOut;
    logic [31:0] quotient;
`ifdef FPD_DIVZERO_FLAG_EN
    logic        divByZero;
`endif

    typedef struct {
        logic [31:0] q;
        logic        z;
        logic        dbz;
        int          lat;
        int          t0;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   pass_cnt = 0;
    int   total_cnt = 0;

    sync_fpd dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .A         (A),
        .isZeroA   (isZeroA),
        .B         (B),
        .isZeroB   (isZeroB),
        .busy      (busy),
        .done      (done),
        .quotient  (quotient),
        .isZeroOut (isZeroOut)
`ifdef FPD_DIVZERO_FLAG_EN
        ,
        .divByZero (divByZero)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    endtask

    always @(negedge clk) begin
        if (done) begin
            if (sb.size() == 0) begin
                total_cnt++;
                $display("FAIL unexpected_done: quotient 0x%08h with no pending operation", quotient);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("quotient", quotient, e.q);
                chk("isZeroOut", 32'(isZeroOut), 32'(e.z));
                chk("latency", 32'(cyc - e.t0), 32'(e.lat));
`ifdef FPD_DIVZERO_FLAG_EN
                chk("divByZero", 32'(divByZero), 32'(e.dbz));
`endif
            end
        end
    end

    task automatic wait_done();
        int n = 0;
        while (!done && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (!done) begin
            total_cnt++;
            $display("FAIL done_timeout: no done within %0d cycles", n);
        end
        @(negedge clk);
    endtask

    task automatic launch(input logic [31:0] a, input logic za, input logic [31:0] b, input logic zb);
        @(negedge clk);
        A = a; isZeroA = za; B = b; isZeroB = zb; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic run_op(input logic [31:0] a, input logic za, input logic [31:0] b, input logic zb,
                          input logic [31:0] eq, input logic ez, input int lat, input logic edbz);
        exp_t e;
        launch(a, za, b, zb);
        e.q = eq; e.z = ez; e.dbz = edbz; e.lat = lat; e.t0 = cyc;
        sb.push_back(e);
        chk("busy_after_start", 32'(busy), 32'd1);
        wait_done();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        rst = 1'b1; start = 1'b0; A = '0; B = '0; isZeroA = 1'b0; isZeroB = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_quotient", quotient, 32'd0);
        chk("reset_isZeroOut", 32'(isZeroOut), 32'd0);
        rst = 1'b0;

        //      A             zA    B             zB    expected      z     lat  dbz
        run_op(32'h40C00000, 1'b0, 32'h40000000, 1'b0, 32'h40400000, 1'b0, 27, 1'b0);
        run_op(32'h3F800000, 1'b0, 32'h40400000, 1'b0, 32'h3EAAAAAA, 1'b0, 27, 1'b0);
        run_op(32'hC1000000, 1'b0, 32'h3F000000, 1'b0, 32'hC1800000, 1'b0, 27, 1'b0);
        run_op(32'h3F800000, 1'b0, 32'h00000000, 1'b1, 32'h7F800000, 1'b0,  2, 1'b1);
        run_op(32'hBF800000, 1'b0, 32'h00000000, 1'b0, 32'hFF800000, 1'b0,  2, 1'b1);
        run_op(32'h00000000, 1'b0, 32'h00000000, 1'b0, 32'h7FC00000, 1'b0,  2, 1'b0);
        run_op(32'h7F000000, 1'b0, 32'h00800000, 1'b0, 32'h7F800000, 1'b0, 27, 1'b0);
        run_op(32'h00800000, 1'b0, 32'h7F000000, 1'b0, 32'h00000000, 1'b1, 27, 1'b0);
        run_op(32'h3F800000, 1'b0, 32'hFF800000, 1'b0, 32'h80000000, 1'b1,  2, 1'b0);
        run_op(32'h40000000, 1'b1, 32'h40000000, 1'b0, 32'h00000000, 1'b1,  2, 1'b0);
        run_op(32'h7F800001, 1'b0, 32'h3F800000, 1'b0, 32'h7FC00000, 1'b0,  2, 1'b0);
        run_op(32'h7F800000, 1'b0, 32'hFF800000, 1'b0, 32'h7FC00000, 1'b0,  2, 1'b0);
        run_op(32'h7F800000, 1'b0, 32'hC0000000, 1'b0, 32'hFF800000, 1'b0,  2, 1'b0);
        run_op(32'h00400000, 1'b0, 32'h3F800000, 1'b0, 32'h00000000, 1'b1,  2, 1'b0);

        // A second start while busy must leave the first operands in charge.
        launch(32'h40C00000, 1'b0, 32'h40000000, 1'b0);
        e.q = 32'h40400000; e.z = 1'b0; e.dbz = 1'b0; e.lat = 27; e.t0 = cyc;
        sb.push_back(e);
        repeat (3) @(negedge clk);
        launch(32'h3F800000, 1'b0, 32'h40400000, 1'b0);
        wait_done();
        repeat (35) @(negedge clk);

        // Reset mid-division discards the operation and clears the outputs.
        launch(32'h3F800000, 1'b0, 32'h40400000, 1'b0);
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_done", 32'(done), 32'd0);
        chk("midrst_quotient", quotient, 32'd0);
        chk("midrst_isZeroOut", 32'(isZeroOut), 32'd0);
        rst = 1'b0;
        run_op(32'hC1000000, 1'b0, 32'h3F000000, 1'b0, 32'hC1800000, 1'b0, 27, 1'b0);
        repeat (35) @(negedge clk);

        total_cnt++;
        if (sb.size() == 0) pass_cnt++;
        else $display("FAIL scoreboard_drain: %0d results never arrived, expected 0", sb.size());

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
